// File: rtl/axi_uart_lite_slave.sv
// AXI4-lite UART Lite style peripheral: 8N1 serial TX/RX with byte FIFOs.
// Define UART_INTR_EN to add the interrupt output port.
module axi_uart_lite_slave #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  uart_axi_araddr,
  input  logic        uart_axi_arvalid,
  output logic        uart_axi_arready,
  output logic [31:0] uart_axi_rdata,
  output logic [1:0]  uart_axi_rresp,
  output logic        uart_axi_rvalid,
  input  logic        uart_axi_rready,
  input  logic [3:0]  uart_axi_awaddr,
  input  logic        uart_axi_awvalid,
  output logic        uart_axi_awready,
  input  logic [31:0] uart_axi_wdata,
  input  logic [3:0]  uart_axi_wstrb,
  input  logic        uart_axi_wvalid,
  output logic        uart_axi_wready,
  output logic [1:0]  uart_axi_bresp,
  output logic        uart_axi_bvalid,
  input  logic        uart_axi_bready,
  input  logic        uart_rxd,
  output logic        uart_txd
`ifdef UART_INTR_EN
  ,
  output logic        interrupt
`endif
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_END  = 16'(CPB - 1);
  localparam logic [15:0] HALF_END = 16'(CPB / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } ser_st_e;

  logic       rdy_en_q;
  logic       aw_held_q, aw_held_d;
  logic       w_held_q, w_held_d;
  logic [1:0] waddr_q, waddr_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic       wstrb0_q, wstrb0_d;
  logic       bvalid_q, bvalid_d;
  logic       rvalid_q, rvalid_d;
  logic [7:0] rdata_q, rdata_d;
  logic       intr_en_q, intr_en_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;

  ser_st_e    tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       txd_q, txd_d;

  logic       rx_s1_q, rx_s2_q;
  ser_st_e    rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;

  logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic       wr_fire, wr_en, ctrl_wr;
  logic       tx_push, tx_pop, tx_flush;
  logic       rx_push, rx_pop, rx_flush;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0] tx_head, rx_head;
  logic [1:0] rsel;
  logic [7:0] stat, rd_val;
  logic       stat_rd, ovr_set, ferr_set;
  logic       unused_ok;

  assign unused_ok = ^{uart_axi_araddr[1:0], uart_axi_awaddr[1:0],
                       uart_axi_wdata[31:8], uart_axi_wstrb[3:1]};

  assign uart_axi_awready = rdy_en_q & ~aw_held_q;
  assign uart_axi_wready  = rdy_en_q & ~w_held_q;
  assign uart_axi_arready = rdy_en_q & ~rvalid_q;
  assign uart_axi_bvalid  = bvalid_q;
  assign uart_axi_bresp   = 2'b00;
  assign uart_axi_rvalid  = rvalid_q;
  assign uart_axi_rresp   = 2'b00;
  assign uart_axi_rdata   = {24'b0, rdata_q};
  assign uart_txd         = txd_q;

  assign aw_hs = uart_axi_awvalid & uart_axi_awready;
  assign w_hs  = uart_axi_wvalid & uart_axi_wready;
  assign ar_hs = uart_axi_arvalid & uart_axi_arready;
  assign b_hs  = bvalid_q & uart_axi_bready;
  assign r_hs  = rvalid_q & uart_axi_rready;

  // Register side effect fires once: bvalid_q blocks a repeat.
  assign wr_fire  = aw_held_q & w_held_q & ~bvalid_q;
  assign wr_en    = wr_fire & wstrb0_q;
  assign tx_push  = wr_en & (waddr_q == 2'd1);
  assign ctrl_wr  = wr_en & (waddr_q == 2'd3);
  assign tx_flush = ctrl_wr & wbyte_q[0];
  assign rx_flush = ctrl_wr & wbyte_q[1];

  assign rsel    = uart_axi_araddr[3:2];
  assign rx_pop  = ar_hs & (rsel == 2'd0);
  assign stat_rd = ar_hs & (rsel == 2'd2);
  assign stat    = {1'b0, ferr_q, ovr_q, intr_en_q,
                    tx_full, tx_empty, rx_full, ~rx_empty};
  assign ovr_set = rx_push & rx_full;

  always_comb begin
    rd_val = 8'h00;
    case (rsel)
      2'd0:    rd_val = rx_empty ? 8'h00 : rx_head;
      2'd2:    rd_val = stat;
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wbyte_d   = wbyte_q;
    wstrb0_d  = wstrb0_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    intr_en_d = ctrl_wr ? wbyte_q[4] : intr_en_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      waddr_d   = uart_axi_awaddr[3:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wbyte_d  = uart_axi_wdata[7:0];
      wstrb0_d = uart_axi_wstrb[0];
    end
    if (wr_fire) bvalid_d = 1'b1;
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
    // A set event in the clearing cycle keeps the flag.
    ovr_d  = (ovr_q & ~stat_rd) | ovr_set;
    ferr_d = (ferr_q & ~stat_rd) | ferr_set;
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      S_IDLE: begin
        if (!tx_empty && !tx_flush) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_head;
          tx_cnt_d = '0;
          txd_d    = 1'b0;
          tx_st_d  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          txd_d    = tx_sh_q[0];
          tx_st_d  = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d   = 1'b1;
            tx_st_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_END) tx_st_d = S_IDLE;
        else tx_cnt_d = tx_cnt_q + 16'd1;
      end
    endcase
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    unique case (rx_st_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_cnt_d = '0;
          rx_st_d  = S_START;
        end
      end
      S_START: begin
        // Mid-start recheck rejects short glitches.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_push  = rx_s2_q;
          ferr_set = ~rx_s2_q;
          rx_st_d  = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      waddr_q   <= '0;
      wbyte_q   <= '0;
      wstrb0_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      intr_en_q <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      txd_q     <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rdy_en_q  <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      waddr_q   <= waddr_d;
      wbyte_q   <= wbyte_d;
      wstrb0_q  <= wstrb0_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      intr_en_q <= intr_en_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      txd_q     <= txd_d;
      rx_s1_q   <= uart_rxd;
      rx_s2_q   <= rx_s1_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

`ifdef UART_INTR_EN
  logic rx_empty_p_q, tx_empty_p_q, intr_q, intr_d;

  always_comb begin
    intr_d = intr_en_q &
             ((rx_empty_p_q & ~rx_empty) | (~tx_empty_p_q & tx_empty));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_empty_p_q <= 1'b1;
      tx_empty_p_q <= 1'b1;
      intr_q       <= 1'b0;
    end else begin
      rx_empty_p_q <= rx_empty;
      tx_empty_p_q <= tx_empty;
      intr_q       <= intr_d;
    end
  end

  assign interrupt = intr_q;
`endif

  uart_lite_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .wdata (wbyte_q),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  uart_lite_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (rx_sh_q),
    .rdata (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

endmodule

module uart_lite_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_uart_lite_slave.sv
// Scoreboard bench for axi_uart_lite_slave: AXI reads and TX line
// bytes are compared against queues filled as stimulus is driven.
module tb_axi_uart_lite_slave;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  araddr, awaddr;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic        rxd, txd;
`ifdef UART_INTR_EN
  logic        interrupt;
  int          intr_cnt = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_exp[$];
  logic [31:0] tx_exp[$];

  axi_uart_lite_slave #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid),
    .uart_axi_arready(arready), .uart_axi_rdata(rdata),
    .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid),
    .uart_axi_rready(rready), .uart_axi_awaddr(awaddr),
    .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
    .uart_axi_wdata(wdata), .uart_axi_wstrb(wstrb),
    .uart_axi_wvalid(wvalid), .uart_axi_wready(wready),
    .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid),
    .uart_axi_bready(bready), .uart_rxd(rxd), .uart_txd(txd)
`ifdef UART_INTR_EN
    , .interrupt(interrupt)
`endif
  );

  always #5 clk = ~clk;

`ifdef UART_INTR_EN
  always @(posedge clk) if (interrupt === 1'b1) intr_cnt++;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int  n;
    logic ah, wh, a_go, w_go;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    ah = 1'b0; wh = 1'b0; n = 0;
    while (!(ah && wh) && n < 50) begin
      a_go = awvalid & awready;
      w_go = wvalid & wready;
      cyc(1);
      if (a_go) begin ah = 1'b1; awvalid = 1'b0; end
      if (w_go) begin wh = 1'b1; wvalid = 1'b0; end
      n++;
    end
    n = 0;
    while (!bvalid && n < 50) begin cyc(1); n++; end
    chk("bvalid", {31'b0, bvalid}, 32'd1);
    chk("bresp", {30'b0, bresp}, 32'd0);
    bready = 1'b1;
    cyc(1);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin cyc(1); n++; end
    cyc(1);
    arvalid = 1'b0;
    chk("rvalid_lat", {31'b0, rvalid}, 32'd1);
    chk("rresp", {30'b0, rresp}, 32'd0);
    d = rdata;
    rready = 1'b1;
    cyc(1);
    rready = 1'b0;
  endtask

  task automatic exp_read(input string tag, input logic [3:0] a,
                          input logic [31:0] e);
    logic [31:0] d;
    rd_exp.push_back(e);
    axi_read(a, d);
    chk(tag, d, rd_exp.pop_front());
  endtask

  task automatic rx_bit(input logic v);
    rxd = v;
    cyc(CPB);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    rxd = 1'b1;
    cyc(2 * CPB);
  endtask

  task automatic wait_tx();
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < 3000) begin cyc(1); n++; end
    if (n >= 3000) chk("tx_timeout", 32'd0, 32'd1);
    cyc(20);
  endtask

  initial begin : tx_mon
    logic [7:0]  b;
    logic [31:0] e;
    @(posedge rstn);
    forever begin
      @(negedge txd);
      repeat (CPB / 2) @(negedge clk);
      chk("tx_start", {31'b0, txd}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      chk("tx_stop", {31'b0, txd}, 32'd1);
      e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 32'h100;
      chk("tx_byte", {24'b0, b}, e);
    end
  end

  initial begin
    rstn = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; rxd = 1'b1;
    #23;
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_wready", {31'b0, wready}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    cyc(1);
    rstn = 1'b1;
    chk("rdy_held", {29'b0, arready, awready, wready}, 32'd0);
    cyc(1);
    chk("rdy_up", {29'b0, arready, awready, wready}, 32'h7);
    exp_read("stat_rst", 4'h8, 32'h04);

    // single TX byte
    tx_exp.push_back(32'h55);
    axi_write(4'h4, 32'h55, 4'hF);
    wait_tx();
    exp_read("stat_tx_done", 4'h8, 32'h04);

    // single RX byte
    send_rx(8'hA3, 1'b1);
    exp_read("stat_rx1", 4'h8, 32'h05);
    exp_read("rx_a3", 4'h0, 32'hA3);
    exp_read("stat_rx0", 4'h8, 32'h04);

    // overrun: five frames into a four deep FIFO
    for (int i = 0; i < 5; i++) send_rx(8'(8'h10 + i), 1'b1);
    exp_read("stat_ovr", 4'h8, 32'h27);
    exp_read("stat_ovr_clr", 4'h8, 32'h07);
    for (int i = 0; i < 4; i++) exp_read("rx_seq", 4'h0, 32'(8'h10 + i));
    exp_read("rx_empty", 4'h0, 32'h0);
    exp_read("stat_drained", 4'h8, 32'h04);

    // framing error and glitch
    send_rx(8'h3C, 1'b0);
    exp_read("stat_ferr", 4'h8, 32'h44);
    exp_read("stat_ferr_clr", 4'h8, 32'h04);
    rxd = 1'b0;
    cyc(1);
    rxd = 1'b1;
    cyc(30);
    exp_read("stat_glitch", 4'h8, 32'h04);

    // W leads AW by three cycles, slow bready
    wdata = 32'h5A; wstrb = 4'h1; wvalid = 1'b1;
    cyc(1);
    wvalid = 1'b0;
    chk("w_held_rdy", {30'b0, awready, wready}, 32'h2);
    cyc(2);
    awaddr = 4'h4; awvalid = 1'b1;
    tx_exp.push_back(32'h5A);
    cyc(1);
    awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("b_hold", {30'b0, bvalid, awready}, 32'h2);
    end
    bready = 1'b1;
    cyc(1);
    bready = 1'b0;
    chk("b_done", {29'b0, bvalid, awready, wready}, 32'h3);
    wait_tx();

    // strobe clear write is ignored
    axi_write(4'h4, 32'h77, 4'hE);
    cyc(30);
    exp_read("stat_nostrb", 4'h8, 32'h04);

    // TX FIFO full: one in flight, four queued, sixth dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tx_exp.push_back(32'(i + 1));
      axi_write(4'h4, 32'(i + 1), 4'h1);
    end
    exp_read("stat_txfull", 4'h8, 32'h08);
    wait_tx();
    exp_read("rd_tx_reg", 4'h4, 32'h0);

    // interrupt enable and RX flush
    axi_write(4'hC, 32'h10, 4'h1);
    exp_read("stat_ien", 4'h8, 32'h14);
    exp_read("rd_ctrl", 4'hC, 32'h0);
`ifdef UART_INTR_EN
    intr_cnt = 0;
`endif
    send_rx(8'h11, 1'b1);
`ifdef UART_INTR_EN
    chk("intr_pulses", 32'(intr_cnt), 32'd1);
`endif
    exp_read("stat_ien_rx", 4'h8, 32'h15);
    exp_read("rx_11", 4'h0, 32'h11);
    send_rx(8'h21, 1'b1);
    send_rx(8'h22, 1'b1);
    axi_write(4'hC, 32'h12, 4'h1);
    exp_read("stat_rxflush", 4'h8, 32'h14);
    cyc(20);
    chk("tx_left", 32'(tx_exp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
